// File: rtl/lif_sweep_ctrl.sv
// Leaky integrate-and-fire sweep sequencer: read-modify-write of every neuron in one SRAM bank.
// Build option: define LIF_SATURATE_EN to clamp v_next instead of wrapping it.
module lif_sweep_ctrl #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned LEAK_SHIFT = 4,
  parameter int          THRESHOLD  = 1000,
  parameter int          V_RESET    = 0,
  localparam int unsigned AW        = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] cur_in,
  input  logic [WIDTH-1:0] sram_rdata,
  output logic [AW-1:0]    sram_addr,
  output logic             sram_we,
  output logic [WIDTH-1:0] sram_wdata,
  output logic             busy,
  output logic             spike_valid,
  output logic [AW-1:0]    spike_id,
  output logic             done
);

  localparam logic signed [WIDTH-1:0] ThrW    = WIDTH'(THRESHOLD);
  localparam logic signed [WIDTH-1:0] VResetW = WIDTH'(V_RESET);
  localparam logic [AW-1:0]           LastIdx = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StUpdate
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic            spike_valid_q, spike_valid_d;
  logic [AW-1:0]   spike_id_q, spike_id_d;
  logic            done_q, done_d;

  // ---------------------------------------------------------------------------
  // Neuron datapath (only meaningful while in StUpdate)
  // ---------------------------------------------------------------------------
  logic signed [WIDTH-1:0] v;
  logic signed [WIDTH-1:0] leak;
  logic signed [WIDTH-1:0] cur;
  logic signed [WIDTH-1:0] v_next;
  logic                    fire;

  assign v    = $signed(sram_rdata);
  assign cur  = $signed(cur_in);
  assign leak = v >>> LEAK_SHIFT;

`ifdef LIF_SATURATE_EN
  logic [WIDTH:0] sum_wide;

  always_comb begin
    sum_wide = {v[WIDTH-1], v} - {leak[WIDTH-1], leak} + {cur[WIDTH-1], cur};
    // Sign bit and the extra guard bit disagree only when the result left the WIDTH range.
    if (sum_wide[WIDTH] != sum_wide[WIDTH-1]) begin
      v_next = sum_wide[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      v_next = sum_wide[WIDTH-1:0];
    end
  end
`else
  // Two's-complement wrap: identical to the low WIDTH bits of the wide sum.
  always_comb begin
    v_next = v - leak + cur;
  end
`endif

  assign fire = (v_next >= ThrW);

  // ---------------------------------------------------------------------------
  // Sweep FSM and SRAM drive
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    sram_addr     = idx_q;
    sram_we       = 1'b0;
    sram_wdata    = '0;
    spike_valid_d = 1'b0;
    spike_id_d    = '0;
    done_d        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRead;
          idx_d   = '0;
        end
      end
      StRead: begin
        state_d = StUpdate;
      end
      StUpdate: begin
        sram_we       = 1'b1;
        sram_wdata    = fire ? VResetW : v_next;
        spike_valid_d = fire;
        spike_id_d    = fire ? idx_q : '0;
        if (idx_q == LastIdx) begin
          // Park idx at zero so the idle address bus stays quiet.
          state_d = StIdle;
          idx_d   = '0;
          done_d  = 1'b1;
        end else begin
          state_d = StRead;
          idx_d   = idx_q + AW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      spike_valid_q <= 1'b0;
      spike_id_q    <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      spike_valid_q <= spike_valid_d;
      spike_id_q    <= spike_id_d;
      done_q        <= done_d;
    end
  end

  assign busy        = (state_q != StIdle);
  assign spike_valid = spike_valid_q;
  assign spike_id    = spike_id_q;
  assign done        = done_q;

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
  a_we_only_busy : assert property (@(posedge clk) disable iff (reset) sram_we |-> busy);
  a_done_idle    : assert property (@(posedge clk) disable iff (reset) done |-> !busy);

endmodule

// File: doc/lif_sweep_ctrl.md
# lif_sweep_ctrl

Sequencer that drives one `sram` membrane-potential bank as its sole read/write initiator. On each `start` it sweeps all DEPTH neurons with a read-modify-write. For each neuron it reads the stored potential, applies shift-based leak plus an input current, and compares the result against a threshold. It writes back either the updated potential or the reset potential, and emits a spike event for each neuron that fired. It sits between the timestep scheduler (`start`/`done`) and the spike router (`spike_*`).

## Interface
- WIDTH, 32, potential/current word width (signed)
- DEPTH, 256, neurons per bank; address width is $clog2(DEPTH)
- LEAK_SHIFT, 4, leak = v >>> LEAK_SHIFT (arithmetic shift)
- THRESHOLD, 1000, signed firing threshold
- V_RESET, 0, signed potential written after a spike
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request one sweep; sampled only in IDLE
- cur_in  in  WIDTH  signed input current for neuron `sram_addr`; sampled in UPDATE
- sram_rdata  in  WIDTH  SRAM `word` output (registered read, 1-cycle latency)
- sram_addr  out  $clog2(DEPTH)  SRAM address
- sram_we  out  1  SRAM write enable
- sram_wdata  out  WIDTH  SRAM write data
- busy  out  1  high whenever state != IDLE
- spike_valid  out  1  one-cycle spike event (registered)
- spike_id  out  $clog2(DEPTH)  index of the neuron that fired
- done  out  1  one-cycle pulse at sweep end (registered)

## Operation
- States: IDLE, READ, UPDATE.
- IDLE: if start=1, go to READ and set idx=0. Otherwise stay in IDLE.
- READ: sram_addr=idx, sram_we=0. The SRAM latches memory[idx] at the edge. The FSM then goes to UPDATE.
- UPDATE: sram_addr=idx, sram_we=1, and sram_rdata holds v. The datapath computes:
  - v_next = v − (v >>> LEAK_SHIFT) + cur_in, evaluated at WIDTH+1 bits and then narrowed (see Configuration).
  - fire = (v_next >= THRESHOLD), a signed compare.
  - sram_wdata = fire ? V_RESET : v_next.
- UPDATE transitions:
  - If idx == DEPTH−1, go to IDLE.
  - Otherwise, idx increments and the FSM goes to READ.
- Registered outputs after an UPDATE edge:
  - If fire, spike_valid=1 and spike_id=idx for the next cycle.
  - If the UPDATE was for the last neuron, done=1 for the next cycle.
- start is ignored while busy; no queuing.
- sram_addr, sram_we and sram_wdata are combinational from state/idx/datapath. sram_we=0 outside UPDATE. sram_wdata=0 outside UPDATE.
- Reset (any time, including mid-sweep): state=IDLE, idx=0. All outputs are 0 while reset is asserted and after it is released. A partial sweep is abandoned, not resumed.

## Timing
- Call the edge that samples start=1 in IDLE E0.
- Neuron i is in READ during cycle (E0+2i, E0+2i+1) and in UPDATE during (E0+2i+1, E0+2i+2). Its write commits at E0+2i+2.
- spike_valid for neuron i is high in cycle (E0+2i+2, E0+2i+3).
- done is high in cycle (E0+2·DEPTH, E0+2·DEPTH+1), coincident with the last neuron's spike_valid.
- busy is high from E0 until E0+2·DEPTH.
- A sweep costs 2·DEPTH cycles. With start held high, one IDLE cycle separates consecutive sweeps, i.e. a period of 2·DEPTH+1.
- No SRAM read and write of the same address occur in one cycle, so the SRAM's read-old-data behaviour is never relied on.

## Configuration
- LIF_SATURATE_EN:
  - Defined: the WIDTH+1-bit v_next is clamped to [−2^(WIDTH−1), 2^(WIDTH−1)−1] before the compare and write-back.
  - Undefined: v_next is truncated to its low WIDTH bits (two's-complement wrap), with no clamp logic.

## Test plan
Bench config: WIDTH=16, DEPTH=4, LEAK_SHIFT=2, THRESHOLD=100, V_RESET=0.
- Baseline: all mem=0, cur_in=10, pulse start → mem becomes {10,10,10,10}; no spike_valid; done at E0+8; busy high for exactly 8 cycles.
- Fire: mem[2]=96, cur_in=30 → 96−24+30=102; mem[2]=0; spike_valid with spike_id=2 at cycle (E0+6, E0+7). Other neurons with mem=0 become 30.
- Negative leak: mem[0]=−8, cur_in=0 → mem[0]=−6 (arithmetic shift); no spike.
- Overflow: mem[1]=32000, cur_in=32767.
  - With LIF_SATURATE_EN: v_next=32767, so spike_id=1 and mem[1]=0.
  - Without it: v_next=−8769, no spike, and mem[1]=−8769.
- Control: pulse start again at E0+3 → ignored, single done. Assert reset at E0+5 → busy/done/spike_valid drop to 0 and state is IDLE. A fresh start then completes a full 8-cycle sweep.
- Back-to-back: hold start=1 → done pulses at E0+8 and E0+17; the second sweep uses the first sweep's written values.
